cache_req_arb: RTL and testbench
================================

# cache_req_arb

Parametrised N-channel cache request arbiter with a registered output stage. It merges independent requesters (fetch, load/store, test drivers) onto the single request port of the cache controller. It generalises the fixed 32-bit {valid, addr, we, wdat} cache packet to configurable address/data width, channel count, byte-enables and a valid/ready handshake. Grants are round-robin, and each accepted request is presented one cycle later on a stable output register.

## Interface
- `NCH`, 2: number of request channels, ≥1
- `AW`, 32: address width
- `DW`, 32: write-data width, multiple of 8; `BW = DW/8` (derived localparam)
- `IDW`, derived: `NCH>1 ? $clog2(NCH) : 1`
- `clk` in 1: clock, rising edge
- `rst_n` in 1: reset, asynchronous assert, active-low
- `req_valid` in NCH: per-channel request valid
- `req_ready` out NCH: per-channel accept, at most one bit set (one-hot or zero)
- `req_addr` in NCH*AW: channel i at `[i*AW +: AW]`
- `req_we` in NCH: 1 = write, 0 = read
- `req_wdat` in NCH*DW: write data, channel i at `[i*DW +: DW]`
- `req_be` in NCH*BW: byte enables, channel i at `[i*BW +: BW]`
- `out_valid` out 1: output packet valid
- `out_ready` in 1: cache controller accepts packet
- `out_addr` out AW; `out_we` out 1; `out_wdat` out DW; `out_be` out BW: packet payload
- `out_id` out IDW: index of the originating channel

## Operation
- Transfer on a channel occurs when `req_valid[i] & req_ready[i]`. Output transfer occurs when `out_valid & out_ready`.
- Slot free: `!out_valid | out_ready`. `req_ready` is all-zero unless the slot is free.
- When the slot is free, round-robin arbitration applies:
  - The search starts at `last+1` (mod NCH) and the first channel with valid set is granted.
  - `req_ready` is combinational from `req_valid`, `out_valid`, `out_ready` and `last`.
- On a channel transfer:
  - The output register loads addr, we and id.
  - If `we=1`, `out_wdat`/`out_be` load the channel's wdat/be.
  - If `we=0`, `out_wdat` is forced to 0 and `out_be` to 0 (read packets carry no data).
  - `last` is updated to the granted index.
  - `out_valid` is set to 1.
- On an output transfer with no new grant, `out_valid` goes to 0. Payload holds its last value.
- Output transfer and new grant in the same cycle: the register reloads and `out_valid` stays 1. This gives full throughput, one packet per cycle.
- While `out_valid & !out_ready`, all out_* signals are stable and `req_ready` = 0.
- Requesters must hold `req_valid` and payload until accepted. Dropping valid before acceptance is permitted; the arbiter has no memory of it.
- With `NCH=1`, the arbiter degenerates to a pipeline register, and `out_id` = 0.

## Timing
- Latency: channel transfer at cycle t, then `out_valid`=1 at t+1.
- Sustained throughput: 1 packet/cycle while `out_ready`=1.
- Fairness: a continuously valid channel is granted within NCH free-slot cycles.
- Reset, async assert: `out_valid`=0, `out_addr`=0, `out_we`=0, `out_wdat`=0, `out_be`=0, `out_id`=0, `last`=NCH-1 (so channel 0 wins first). `req_ready`=0 while `rst_n`=0.
- Reset mid-transfer: a pending output packet is discarded, not replayed.
- Deassertion is assumed synchronised externally. The first grant is possible in the first cycle after release.

## Configuration
- `CACHE_REQ_ARB_BE_EN` defined: `req_be`/`out_be` are honoured as described.
- Undefined: `req_be` is ignored. `out_be` = all-ones for writes and 0 for reads. Ports remain present so the interface is unchanged.

## Structure
- Package `cache_req_pkg`:
  - default-width localparams `CACHE_AW`=32, `CACHE_DW`=32;
  - packed `cache_req_t` {valid, addr, we, be, wdat, id} at default widths;
  - helper functions `mk_read`, `mk_write`, `mk_null` producing `cache_req_t`, used by benches.
- Sub-module `rr_arb` (`NCH` param): takes the request vector and `last`, returns a one-hot grant and encoded index. It is purely combinational; `last` is owned by `cache_req_arb`.

## Test plan
- Reset: `rst_n`=0 with `req_valid`=2'b11 → all outputs 0 and `req_ready`=0. First cycle after release: `req_ready`=2'b01, then next cycle `out_id`=0.
- Read: ch0 read 0x1000, wdat=0xDEADBEEF, `out_ready`=1 → next cycle `out_addr`=0x1000, `out_we`=0, `out_wdat`=0, `out_be`=0.
- Round-robin: both channels valid continuously, `out_ready`=1 → `out_id` sequence 0,1,0,1, one packet per cycle, no bubbles.
- Backpressure: `out_ready`=0 for 5 cycles holding write 0x2004/0x12345678/be=4'b0011 → output stable, `req_ready`=0. Release → packet consumed, new grant the same cycle.
- BE macro: write be=4'b0100 → `out_be`=4'b0100 with `CACHE_REQ_ARB_BE_EN`, 4'b1111 without.
- Reset while `out_valid`=1 → `out_valid`=0 immediately (async), and the packet is not re-emitted after release.

Source files
------------

// File: rtl/cache_req_pkg.sv
// ---------------------------------------------------------------------------
// cache_req_pkg
// Shared definitions for the cache request arbiter:
//   - default address / data widths of the cache request packet
//   - cache_req_t : packed {valid, addr, we, be, wdat, id} at default widths
//   - mk_read / mk_write / mk_null : packet builders for requesters and benches
// ---------------------------------------------------------------------------
package cache_req_pkg;

    localparam int CACHE_AW  = 32;
    localparam int CACHE_DW  = 32;
    localparam int CACHE_BW  = CACHE_DW / 8;
    localparam int CACHE_IDW = 1;

    typedef struct packed {
        logic                 valid;
        logic [CACHE_AW-1:0]  addr;
        logic                 we;
        logic [CACHE_BW-1:0]  be;
        logic [CACHE_DW-1:0]  wdat;
        logic [CACHE_IDW-1:0] id;
    } cache_req_t;

    // Empty packet: every field cleared.
    function automatic cache_req_t mk_null();
        cache_req_t r;
        r = '{valid: 1'b0, addr: {CACHE_AW{1'b0}}, we: 1'b0, be: {CACHE_BW{1'b0}},
              wdat: {CACHE_DW{1'b0}}, id: {CACHE_IDW{1'b0}}};
        return r;
    endfunction

    // Read packet: carries no data and no byte enables.
    function automatic cache_req_t mk_read(input logic [CACHE_AW-1:0]  addr,
                                           input logic [CACHE_IDW-1:0] id);
        cache_req_t r;
        r       = mk_null();
        r.valid = 1'b1;
        r.addr  = addr;
        r.id    = id;
        return r;
    endfunction

    // Write packet with data and byte enables.
    function automatic cache_req_t mk_write(input logic [CACHE_AW-1:0]  addr,
                                            input logic [CACHE_DW-1:0]  wdat,
                                            input logic [CACHE_BW-1:0]  be,
                                            input logic [CACHE_IDW-1:0] id);
        cache_req_t r;
        r       = mk_null();
        r.valid = 1'b1;
        r.addr  = addr;
        r.we    = 1'b1;
        r.be    = be;
        r.wdat  = wdat;
        r.id    = id;
        return r;
    endfunction

endpackage

// File: rtl/cache_req_arb_rr_arb.sv
// ---------------------------------------------------------------------------
// rr_arb
// Purely combinational round-robin picker. The search starts at last+1
// (mod NCH) and the first requesting channel wins. The pointer itself is
// stored by the parent.
// Ports:
//   req     in  NCH : request vector
//   last    in  IDW : index granted most recently
//   gnt     out NCH : one-hot grant (all zero when nothing requests)
//   gnt_idx out IDW : encoded index of the grant (0 when nothing requests)
// ---------------------------------------------------------------------------
module rr_arb
    import cache_req_pkg::*;
#(
    parameter int NCH = 2,
    parameter int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic [NCH-1:0] req,
    input  logic [IDW-1:0] last,
    output logic [NCH-1:0] gnt,
    output logic [IDW-1:0] gnt_idx
);

    logic found_s;
    int   cand_s;

    // Walk the channels in rotated order starting just after the last winner.
    always_comb begin
        gnt     = {NCH{1'b0}};
        gnt_idx = {IDW{1'b0}};
        found_s = 1'b0;
        cand_s  = 0;
        for (int k = 1; k <= NCH; k++) begin
            cand_s = (int'(last) + k) % NCH;
            if (!found_s && req[cand_s]) begin
                found_s     = 1'b1;
                gnt[cand_s] = 1'b1;
                gnt_idx     = IDW'(cand_s);
            end else begin
                found_s = found_s;
            end
        end
    end

endmodule

// File: rtl/cache_req_arb.sv
// ---------------------------------------------------------------------------
// cache_req_arb
// N-channel round-robin cache request arbiter with a registered output slot.
// A granted request appears on out_* one cycle later; the slot reloads in the
// same cycle it drains, so one packet per cycle is sustained.
//
// Build option: CACHE_REQ_ARB_BE_EN
//   defined   : write packets carry the requester's byte enables
//   undefined : req_be is ignored, writes carry all-ones byte enables
//   Reads always carry wdat = 0 and be = 0.
//
// Ports:
//   clk, rst_n            clock, async active-low reset
//   req_valid/req_ready   per-channel handshake (req_ready one-hot or zero)
//   req_addr/we/wdat/be   per-channel payload, flattened channel-major
//   out_valid/out_ready   output handshake
//   out_addr/we/wdat/be   registered packet payload
//   out_id                index of the channel the packet came from
// ---------------------------------------------------------------------------
module cache_req_arb
    import cache_req_pkg::*;
#(
    parameter int NCH = 2,
    parameter int AW  = CACHE_AW,
    parameter int DW  = CACHE_DW,
    localparam int BW  = DW / 8,
    localparam int IDW = (NCH > 1) ? $clog2(NCH) : 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [NCH-1:0]    req_valid,
    output logic [NCH-1:0]    req_ready,
    input  logic [NCH*AW-1:0] req_addr,
    input  logic [NCH-1:0]    req_we,
    input  logic [NCH*DW-1:0] req_wdat,
    input  logic [NCH*BW-1:0] req_be,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [AW-1:0]     out_addr,
    output logic              out_we,
    output logic [DW-1:0]     out_wdat,
    output logic [BW-1:0]     out_be,
    output logic [IDW-1:0]    out_id
);

    logic [NCH-1:0] gnt_s;
    logic [IDW-1:0] gnt_idx_s;
    logic [NCH-1:0] ready_s;
    logic           slot_free_s;
    logic           xfer_s;
    logic [AW-1:0]  sel_addr_s;
    logic           sel_we_s;
    logic [DW-1:0]  ld_wdat_s;
    logic [BW-1:0]  ld_be_s;

    logic           out_valid_r;
    logic [AW-1:0]  out_addr_r;
    logic           out_we_r;
    logic [DW-1:0]  out_wdat_r;
    logic [BW-1:0]  out_be_r;
    logic [IDW-1:0] out_id_r;
    logic [IDW-1:0] last_r;

    rr_arb #(
        .NCH (NCH),
        .IDW (IDW)
    ) u_rr_arb (
        .req     (req_valid),
        .last    (last_r),
        .gnt     (gnt_s),
        .gnt_idx (gnt_idx_s)
    );

    // Accept only into a free slot; rst_n gates ready because the slot reads
    // as empty while reset is held.
    always_comb begin
        slot_free_s = ~out_valid_r | out_ready;
        if (rst_n && slot_free_s) begin
            ready_s = gnt_s;
        end else begin
            ready_s = {NCH{1'b0}};
        end
        xfer_s = |(req_valid & ready_s);
    end

    // Select the granted channel's payload; reads are stripped of data.
    always_comb begin
        sel_addr_s = req_addr[int'(gnt_idx_s)*AW +: AW];
        sel_we_s   = req_we[gnt_idx_s];
        if (sel_we_s) begin
            ld_wdat_s = req_wdat[int'(gnt_idx_s)*DW +: DW];
`ifdef CACHE_REQ_ARB_BE_EN
            ld_be_s   = req_be[int'(gnt_idx_s)*BW +: BW];
`else
            ld_be_s   = {BW{1'b1}};
`endif
        end else begin
            ld_wdat_s = {DW{1'b0}};
            ld_be_s   = {BW{1'b0}};
        end
    end

`ifndef CACHE_REQ_ARB_BE_EN
    // Byte enables are not used in this build; keep the port for interface parity.
    logic be_unused_s;
    assign be_unused_s = ^req_be;
`endif

    // Output slot and round-robin pointer; reset drops any pending packet.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_r <= 1'b0;
            out_addr_r  <= {AW{1'b0}};
            out_we_r    <= 1'b0;
            out_wdat_r  <= {DW{1'b0}};
            out_be_r    <= {BW{1'b0}};
            out_id_r    <= {IDW{1'b0}};
            last_r      <= IDW'(NCH - 1);
        end else if (xfer_s) begin
            out_valid_r <= 1'b1;
            out_addr_r  <= sel_addr_s;
            out_we_r    <= sel_we_s;
            out_wdat_r  <= ld_wdat_s;
            out_be_r    <= ld_be_s;
            out_id_r    <= gnt_idx_s;
            last_r      <= gnt_idx_s;
        end else if (out_ready) begin
            out_valid_r <= 1'b0;
        end else begin
            out_valid_r <= out_valid_r;
        end
    end

    assign req_ready = ready_s;
    assign out_valid = out_valid_r;
    assign out_addr  = out_addr_r;
    assign out_we    = out_we_r;
    assign out_wdat  = out_wdat_r;
    assign out_be    = out_be_r;
    assign out_id    = out_id_r;

endmodule

// File: tb/tb_cache_req_arb.sv
// ---------------------------------------------------------------------------
// tb_cache_req_arb
// Self-checking bench for cache_req_arb (NCH=2, AW=32, DW=32): a table of
// directed cycles, hand-written backpressure / reset sequences, and a random
// phase compared against a transaction-level model. Honours
// CACHE_REQ_ARB_BE_EN for expected byte enables.
// ---------------------------------------------------------------------------
module tb_cache_req_arb;
    import cache_req_pkg::*;

    localparam int NCH = 2;
    localparam int AW  = 32;
    localparam int DW  = 32;
    localparam int BW  = 4;

    localparam logic [31:0] WD0 = 32'hDEADBEEF;
    localparam logic [31:0] WD1 = 32'hCAFEF00D;
    localparam logic [3:0]  BE0 = 4'b0100;
    localparam logic [3:0]  BE1 = 4'b0011;
`ifdef CACHE_REQ_ARB_BE_EN
    localparam bit BE_EN = 1'b1;
`else
    localparam bit BE_EN = 1'b0;
`endif
    localparam logic [3:0] XBE0 = BE_EN ? BE0 : 4'b1111;
    localparam logic [3:0] XBE1 = BE_EN ? BE1 : 4'b1111;

    logic              clk;
    logic              rst_n;
    logic [NCH-1:0]    req_valid;
    logic [NCH-1:0]    req_ready;
    logic [NCH*AW-1:0] req_addr;
    logic [NCH-1:0]    req_we;
    logic [NCH*DW-1:0] req_wdat;
    logic [NCH*BW-1:0] req_be;
    logic              out_valid;
    logic              out_ready;
    logic [AW-1:0]     out_addr;
    logic              out_we;
    logic [DW-1:0]     out_wdat;
    logic [BW-1:0]     out_be;
    logic              out_id;

    cache_req_arb #(.NCH(NCH), .AW(AW), .DW(DW)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req_valid (req_valid),
        .req_ready (req_ready),
        .req_addr  (req_addr),
        .req_we    (req_we),
        .req_wdat  (req_wdat),
        .req_be    (req_be),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_addr  (out_addr),
        .out_we    (out_we),
        .out_wdat  (out_wdat),
        .out_be    (out_be),
        .out_id    (out_id)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_outs(input string tag, input logic ov, input logic id,
                            input logic [31:0] addr, input logic we,
                            input logic [31:0] wdat, input logic [3:0] be);
        chk({tag, ".out_valid"}, 64'(out_valid), 64'(ov));
        chk({tag, ".out_id"},    64'(out_id),    64'(id));
        chk({tag, ".out_addr"},  64'(out_addr),  64'(addr));
        chk({tag, ".out_we"},    64'(out_we),    64'(we));
        chk({tag, ".out_wdat"},  64'(out_wdat),  64'(wdat));
        chk({tag, ".out_be"},    64'(out_be),    64'(be));
    endtask

    typedef struct {
        logic [1:0]  valid;
        logic [1:0]  we;
        logic        ordy;
        logic [31:0] a0;
        logic [31:0] a1;
        logic [1:0]  e_rdy;
        logic        e_ov;
        logic        e_id;
        logic [31:0] e_addr;
        logic        e_we;
        logic [31:0] e_wdat;
        logic [3:0]  e_be;
    } vec_t;

    function automatic vec_t mkv(logic [1:0] v, logic [1:0] we, logic ordy,
                                 logic [31:0] a0, logic [31:0] a1, logic [1:0] er,
                                 logic eov, logic eid, logic [31:0] ea, logic ewe,
                                 logic [31:0] ewd, logic [3:0] ebe);
        vec_t r;
        r = '{valid: v, we: we, ordy: ordy, a0: a0, a1: a1, e_rdy: er, e_ov: eov,
              e_id: eid, e_addr: ea, e_we: ewe, e_wdat: ewd, e_be: ebe};
        return r;
    endfunction

    vec_t vecs[9];

    // Reset with both channels requesting; everything must read zero.
    task automatic do_reset();
        rst_n     = 1'b0;
        req_valid = 2'b11;
        out_ready = 1'b1;
        #1;
        chk("rst.req_ready", 64'(req_ready), 64'd0);
        chk_outs("rst", 1'b0, 1'b0, 32'h0, 1'b0, 32'h0, 4'h0);
        @(posedge clk);
        @(posedge clk);
        #1;
        chk("rst_hold.req_ready", 64'(req_ready), 64'd0);
        chk("rst_hold.out_valid", 64'(out_valid), 64'd0);
        rst_n = 1'b1;
    endtask

    // Transaction-level model state
    logic        m_valid;
    logic        m_id;
    logic        m_last;
    logic [31:0] m_addr;
    logic        m_we;
    logic [31:0] m_wdat;
    logic [3:0]  m_be;
    int          best;
    int          bestd;
    int          d;
    logic [1:0]  e_rdy;
    logic [31:0] ra [NCH];
    logic [31:0] rw [NCH];
    logic [3:0]  rb [NCH];
    cache_req_t  p;

    initial begin
        rst_n     = 1'b0;
        req_valid = 2'b00;
        req_we    = 2'b00;
        req_addr  = 64'h0;
        req_wdat  = {WD1, WD0};
        req_be    = {BE1, BE0};
        out_ready = 1'b1;

        vecs[0] = mkv(2'b11, 2'b00, 1'b1, 32'h1000, 32'h2000, 2'b01, 1'b1, 1'b0, 32'h1000, 1'b0, 32'h0, 4'h0);
        vecs[1] = mkv(2'b11, 2'b00, 1'b1, 32'h1100, 32'h2100, 2'b10, 1'b1, 1'b1, 32'h2100, 1'b0, 32'h0, 4'h0);
        vecs[2] = mkv(2'b11, 2'b00, 1'b1, 32'h1200, 32'h2200, 2'b01, 1'b1, 1'b0, 32'h1200, 1'b0, 32'h0, 4'h0);
        vecs[3] = mkv(2'b11, 2'b00, 1'b1, 32'h1200, 32'h2200, 2'b10, 1'b1, 1'b1, 32'h2200, 1'b0, 32'h0, 4'h0);
        vecs[4] = mkv(2'b10, 2'b10, 1'b1, 32'h1200, 32'h2004, 2'b10, 1'b1, 1'b1, 32'h2004, 1'b1, WD1, XBE1);
        vecs[5] = mkv(2'b00, 2'b00, 1'b1, 32'h1200, 32'h2004, 2'b00, 1'b0, 1'b1, 32'h2004, 1'b1, WD1, XBE1);
        vecs[6] = mkv(2'b01, 2'b01, 1'b0, 32'h3000, 32'h2004, 2'b01, 1'b1, 1'b0, 32'h3000, 1'b1, WD0, XBE0);
        vecs[7] = mkv(2'b11, 2'b01, 1'b0, 32'h3000, 32'h2008, 2'b00, 1'b1, 1'b0, 32'h3000, 1'b1, WD0, XBE0);
        vecs[8] = mkv(2'b11, 2'b11, 1'b1, 32'h3000, 32'h2008, 2'b10, 1'b1, 1'b1, 32'h2008, 1'b1, WD1, XBE1);

        #2;
        do_reset();

        // Directed table: first grant right after release, 0/1 alternation,
        // drain with payload hold, stall, and byte-enable handling.
        for (int i = 0; i < 9; i++) begin
            req_valid = vecs[i].valid;
            req_we    = vecs[i].we;
            out_ready = vecs[i].ordy;
            req_addr  = {vecs[i].a1, vecs[i].a0};
            #1;
            chk($sformatf("vec%0d.req_ready", i), 64'(req_ready), 64'(vecs[i].e_rdy));
            @(posedge clk);
            #1;
            chk_outs($sformatf("vec%0d", i), vecs[i].e_ov, vecs[i].e_id, vecs[i].e_addr,
                     vecs[i].e_we, vecs[i].e_wdat, vecs[i].e_be);
        end

        // Backpressure: packet held for 5 stalled cycles, then drained and
        // replaced in the same cycle.
        do_reset();
        p = mk_write(32'h2004, 32'h12345678, 4'b0011, 1'b0);
        req_valid = 2'b01;
        req_we    = {1'b1, p.we};
        req_addr  = {32'h2400, p.addr};
        req_wdat  = {32'h55AA55AA, p.wdat};
        req_be    = {4'b1000, p.be};
        out_ready = 1'b0;
        #1;
        chk("bp_load.req_ready", 64'(req_ready), 64'b01);
        @(posedge clk);
        #1;
        chk_outs("bp_load", 1'b1, 1'b0, 32'h2004, 1'b1, 32'h12345678, BE_EN ? 4'b0011 : 4'b1111);
        req_valid = 2'b10;
        for (int c = 0; c < 5; c++) begin
            #1;
            chk($sformatf("bp_stall%0d.req_ready", c), 64'(req_ready), 64'd0);
            @(posedge clk);
            #1;
            chk_outs($sformatf("bp_stall%0d", c), 1'b1, 1'b0, 32'h2004, 1'b1, 32'h12345678,
                     BE_EN ? 4'b0011 : 4'b1111);
        end
        out_ready = 1'b1;
        #1;
        chk("bp_release.req_ready", 64'(req_ready), 64'b10);
        @(posedge clk);
        #1;
        chk_outs("bp_release", 1'b1, 1'b1, 32'h2400, 1'b1, 32'h55AA55AA, BE_EN ? 4'b1000 : 4'b1111);

        // Reset while a packet is pending: cleared at once, never re-emitted.
        req_valid = 2'b00;
        out_ready = 1'b0;
        #1;
        rst_n = 1'b0;
        #1;
        chk("mid_rst.out_valid", 64'(out_valid), 64'd0);
        chk("mid_rst.out_addr",  64'(out_addr),  64'd0);
        chk("mid_rst.req_ready", 64'(req_ready), 64'd0);
        @(posedge clk);
        #1;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        for (int c = 0; c < 2; c++) begin
            @(posedge clk);
            #1;
            chk($sformatf("post_rst%0d.out_valid", c), 64'(out_valid), 64'd0);
        end

        // Random phase against the transaction-level model (state after reset).
        m_valid = 1'b0; m_id = 1'b0; m_last = 1'b1; m_addr = 32'h0;
        m_we = 1'b0; m_wdat = 32'h0; m_be = 4'h0;
        for (int n = 0; n < 400; n++) begin
            for (int c = 0; c < NCH; c++) begin
                ra[c] = $urandom;
                rw[c] = $urandom;
                rb[c] = 4'($urandom_range(0, 15));
            end
            req_valid = 2'($urandom_range(0, 3));
            req_we    = 2'($urandom_range(0, 3));
            out_ready = ($urandom_range(0, 3) != 0);
            req_addr  = {ra[1], ra[0]};
            req_wdat  = {rw[1], rw[0]};
            req_be    = {rb[1], rb[0]};
            // Winner: valid channel at the smallest rotated distance after last.
            best  = -1;
            bestd = NCH + 1;
            if (!m_valid || out_ready) begin
                for (int c = 0; c < NCH; c++) begin
                    d = (c - int'(m_last) - 1 + 2 * NCH) % NCH;
                    if (req_valid[c] && d < bestd) begin
                        bestd = d;
                        best  = c;
                    end
                end
            end
            e_rdy = (best >= 0) ? 2'(1 << best) : 2'b00;
            #1;
            chk($sformatf("rnd%0d.req_ready", n), 64'(req_ready), 64'(e_rdy));
            if (best >= 0) begin
                m_valid = 1'b1;
                m_id    = best[0];
                m_last  = best[0];
                m_addr  = ra[best];
                m_we    = req_we[best];
                m_wdat  = m_we ? rw[best] : 32'h0;
                m_be    = m_we ? (BE_EN ? rb[best] : 4'b1111) : 4'h0;
            end else if (out_ready) begin
                m_valid = 1'b0;
            end
            @(posedge clk);
            #1;
            chk_outs($sformatf("rnd%0d", n), m_valid, m_id, m_addr, m_we, m_wdat, m_be);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
